instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/cpu_defs.sv | 9 +
 rtl/instruction_loader_if.sv | 8 +
 rtl/byte_packer.sv | 26 ++
 rtl/instruction_loader.sv | 63 ++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared loader state encoding, default geometry and header decode.
package cpu_defs;
  localparam int DEPTH_DEFAULT = 256;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0;
  typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECK, DONE, ERROR} state_t;
  function automatic logic [8:0] word_count(input logic [7:0] n);
    return n == 8'd0 ? 9'd256 : {1'b0, n};
  endfunction
endpackage

// File: rtl/instruction_loader_if.sv
// instruction_loader_if: program byte stream plus instruction-memory write port.
interface instruction_loader_if;
  logic [7:0] byte_in;
  logic byte_valid, byte_ready, wr_en;
  logic [31:0] wr_address, wr_data;
  modport master(input byte_in, byte_valid, output byte_ready, wr_en, wr_address, wr_data);
  modport slave(output byte_in, byte_valid, input byte_ready, wr_en, wr_address, wr_data);
endinterface

// File: rtl/byte_packer.sv
// byte_packer: shifts little-endian bytes into a 32-bit word and flags the 4th byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        complete
);
  logic [23:0] word;
  logic [1:0] cnt;
  assign word_next = {byte_in, word};
  assign complete = en && cnt == 2'd3;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word <= '0;
      cnt <= '0;
    end else if (clr) begin
      word <= '0;
      cnt <= '0;
    end else if (en) begin
      word <= word_next[31:8];
      cnt <= cnt + 2'd1;
    end
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: receives a framed program, writes it word by word and releases the CPU on a good checksum.
module instruction_loader import cpu_defs::*; #(
  parameter int          DEPTH     = DEPTH_DEFAULT,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  instruction_loader_if.master bus,
  output logic cpu_hold,
  output logic done,
  output logic error
);
  state_t state, state_nxt;
  logic [8:0] n_words, k;
  logic [7:0] csum;
  logic [31:0] word_next;
  logic accept, clr, complete;
  assign accept = bus.byte_valid && bus.byte_ready;
  assign clr = start && (state == IDLE || state == DONE || state == ERROR);
  byte_packer u_packer (
    .clk(clk), .rst(rst), .clr(clr), .en(accept && state == DATA),
    .byte_in(bus.byte_in), .word_next(word_next), .complete(complete)
  );
  always_comb begin
    state_nxt = state;
    bus.byte_ready = state == HEADER || state == DATA || state == CHECK;
    cpu_hold = state != DONE;
    done = state == DONE;
    error = state == ERROR;
    if (clr) state_nxt = HEADER;
    else if (accept)
      state_nxt = state == HEADER ? (int'(word_count(bus.byte_in)) > DEPTH ? ERROR : DATA)
                : state == DATA   ? (complete && k + 9'd1 == n_words ? CHECK : DATA)
                : (bus.byte_in == csum ? DONE : ERROR);
  end
  // The write port registers the completed word so it holds steady between pulses.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      n_words <= '0;
      k <= '0;
      csum <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_address <= BASE_ADDR;
      bus.wr_data <= '0;
    end else begin
      state <= state_nxt;
      bus.wr_en <= complete;
      if (clr) begin
        n_words <= '0;
        k <= '0;
        csum <= '0;
      end
      if (accept && state == HEADER) n_words <= word_count(bus.byte_in);
      if (accept && state == DATA) csum <= csum ^ bus.byte_in;
      if (complete) begin
        k <= k + 9'd1;
        bus.wr_address <= BASE_ADDR + {21'd0, k, 2'b00};
        bus.wr_data <= word_next;
      end
    end
endmodule
